afifo_wr_ctrl: RTL and testbench

Write-domain control for the asynchronous FIFO. It owns the binary/Gray write pointer, synchronises the read pointer into `wclk`, and generates the memory write enable and address. It also produces `wfull`, an optional almost-full flag, a fill level and a sticky overflow flag. It sits directly behind the write interface the write monitor samples, and it drives the dual-port RAM and the read-domain pointer synchroniser.

---
 rtl/afifo_pkg.sv | 25 ++
 rtl/afifo_wr_ctrl_if.sv | 31 +++
 rtl/afifo_sync2.sv | 28 ++
 rtl/afifo_wr_ctrl.sv | 126 ++++++++++++
 tb/tb_afifo_wr_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared package for the asynchronous FIFO (write- and read-domain controllers).
// Holds the default geometry, the pointer type and the Gray-code helpers.
package afifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  // Binary to Gray; callers zero-extend narrower pointers and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bundle of the asynchronous FIFO: write request, read pointer from
// the read domain, overflow clear, and the controller's RAM/status outputs.
// The controller uses the slave modport; the write-side producer uses master.
interface afifo_wr_ctrl_if
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH = afifo_pkg::ADDR_WIDTH
);

  logic                  winc;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wovf_clr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, rptr, wovf_clr,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, rptr, wovf_clr,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/afifo_sync2.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
// Shared by the write-side (rptr) and read-side (wptr) controllers.
module afifo_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain control of the asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchroniser, RAM write strobe/address, full flag, fill level
// and sticky overflow.
// Optional feature: define AFIFO_ALMOST_FULL_EN to build the almost-full
// threshold compare; otherwise walmost_full is tied low.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH = afifo_pkg::ADDR_WIDTH,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2
) (
  input logic            wclk,
  input logic            wrst_n,
  afifo_wr_ctrl_if.slave wif
);

  localparam int PtrW  = ADDR_WIDTH + 1;
  localparam int Depth = 2**ADDR_WIDTH;

  // A threshold outside 1..Depth would make the almost-full flag meaningless.
  if (AF_THRESH < 1 || AF_THRESH > Depth) begin : g_badThresh
    $error("afifo_wr_ctrl: AF_THRESH out of range");
  end

  logic            r_wrActive;
  logic [PtrW-1:0] r_wbin;
  logic [PtrW-1:0] r_wptr;
  logic            r_wfull;
  logic [PtrW-1:0] r_wlevel;
  logic            r_woverflow;

  logic            w_wen;
  logic [PtrW-1:0] w_wbinNext;
  logic [PtrW-1:0] w_wgrayNext;
  logic [PtrW-1:0] w_wq2Rptr;
  logic [PtrW-1:0] w_wq2RptrBin;
  logic [PtrW-1:0] w_fullCmp;
  logic            w_wfullNext;
  logic [PtrW-1:0] w_wlevelNext;

  // rptr is asynchronous to wclk; this is the only place it is sampled.
  afifo_sync2 #(
    .WIDTH (PtrW)
  ) u_rptrSync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .i_d   (wif.rptr),
    .o_q   (w_wq2Rptr)
  );

  // Goes high on the first edge after reset release; keeps wen low while the
  // block is held in reset even if the write side keeps winc asserted.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wrActive <= 1'b0;
    end else begin
      r_wrActive <= 1'b1;
    end
  end

  // Next-state pointer arithmetic: a write that hits a full FIFO is dropped.
  // Full means the next Gray write pointer equals the synchronised read
  // pointer with its two MSBs inverted (same address, one lap ahead).
  assign w_wen        = wif.winc & ~r_wfull & r_wrActive;
  assign w_wbinNext   = r_wbin + PtrW'(w_wen);
  assign w_wgrayNext  = PtrW'(bin2gray(32'(w_wbinNext)));
  assign w_wq2RptrBin = PtrW'(gray2bin(32'(w_wq2Rptr)));
  assign w_fullCmp    = {~w_wq2Rptr[ADDR_WIDTH:ADDR_WIDTH-1], w_wq2Rptr[ADDR_WIDTH-2:0]};
  assign w_wfullNext  = (w_wgrayNext == w_fullCmp);
  assign w_wlevelNext = w_wbinNext - w_wq2RptrBin;

  // Pointer, full flag and level all update on the same edge as the write.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_wlevel <= '0;
    end else begin
      r_wbin   <= w_wbinNext;
      r_wptr   <= w_wgrayNext;
      r_wfull  <= w_wfullNext;
      r_wlevel <= w_wlevelNext;
    end
  end

  // Sticky overflow: a write attempt while full sets it, and a simultaneous
  // clear loses so no overflow event is ever missed by software.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_woverflow <= 1'b0;
    end else if (wif.winc & r_wfull) begin
      r_woverflow <= 1'b1;
    end else if (wif.wovf_clr) begin
      r_woverflow <= 1'b0;
    end
  end

`ifdef AFIFO_ALMOST_FULL_EN
  logic r_walmostFull;
  logic w_walmostFullNext;

  assign w_walmostFullNext = (int'(w_wlevelNext) >= AF_THRESH);

  // Almost-full tracks the same next-level value as wlevel, so they agree.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_walmostFull <= 1'b0;
    end else begin
      r_walmostFull <= w_walmostFullNext;
    end
  end

  assign wif.walmost_full = r_walmostFull;
`else
  assign wif.walmost_full = 1'b0;
`endif

  assign wif.wen       = w_wen;
  assign wif.waddr     = r_wbin[ADDR_WIDTH-1:0];
  assign wif.wptr      = r_wptr;
  assign wif.wfull     = r_wfull;
  assign wif.wlevel    = r_wlevel;
  assign wif.woverflow = r_woverflow;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed self-checking bench for afifo_wr_ctrl (depth 16, AF_THRESH 14).
// Almost-full expectations follow AFIFO_ALMOST_FULL_EN as defined for the build.
module tb_afifo_wr_ctrl;

  localparam int AW = 4;

  logic wclk = 1'b0;
  logic wrst_n;
  int   checks = 0;
  int   errors = 0;

  afifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) wif ();

  afifo_wr_ctrl #(
    .ADDR_WIDTH (AW),
    .AF_THRESH  (14)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wif    (wif)
  );

  // Free-running write clock, 10 time units per period.
  always #5 wclk = ~wclk;

  function automatic logic [31:0] grayOf(input int b);
    logic [31:0] v;
    v = b;
    return v ^ (v >> 1);
  endfunction

  function automatic logic [31:0] expAf(input int lvl);
`ifdef AFIFO_ALMOST_FULL_EN
    return (lvl >= 14) ? 32'd1 : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  task automatic applyStimulus(input logic inc, input logic clr, input logic [AW:0] rp);
    wif.winc     = inc;
    wif.wovf_clr = clr;
    wif.rptr     = rp;
  endtask

  task automatic tick();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [AW:0] rp;

    // Reset held with a write request pending.
    $display("[TB] reset with winc held");
    wrst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, '0);
    repeat (3) tick();
    checkOutput("rstWen", 32'(wif.wen), 0);
    checkOutput("rstWaddr", 32'(wif.waddr), 0);
    checkOutput("rstWptr", 32'(wif.wptr), 0);
    checkOutput("rstWfull", 32'(wif.wfull), 0);
    checkOutput("rstAlmost", 32'(wif.walmost_full), 0);
    checkOutput("rstWlevel", 32'(wif.wlevel), 0);
    checkOutput("rstOvf", 32'(wif.woverflow), 0);

    // Release reset, then start writing from address 0.
    wrst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    checkOutput("idleWen", 32'(wif.wen), 0);
    applyStimulus(1'b1, 1'b0, '0);
    #1;
    checkOutput("firstWen", 32'(wif.wen), 1);
    checkOutput("firstWaddr", 32'(wif.waddr), 0);

    // 16 back-to-back writes with the read pointer parked at 0.
    $display("[TB] fill to full");
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput("fillLevel", 32'(wif.wlevel), i);
      checkOutput("fillWptr", 32'(wif.wptr), grayOf(i));
      checkOutput("fillWaddr", 32'(wif.waddr), i % 16);
      checkOutput("fillWfull", 32'(wif.wfull), (i == 16) ? 1 : 0);
      checkOutput("fillAlmost", 32'(wif.walmost_full), expAf(i));
      checkOutput("fillWen", 32'(wif.wen), (i < 16) ? 1 : 0);
    end
    checkOutput("fullWptr", 32'(wif.wptr), 32'b11000);
    checkOutput("preOvf", 32'(wif.woverflow), 0);

    // 17th write while full is dropped and sets the sticky overflow.
    $display("[TB] overflow");
    tick();
    checkOutput("ovfSet", 32'(wif.woverflow), 1);
    checkOutput("ovfWptr", 32'(wif.wptr), 32'b11000);
    checkOutput("ovfWaddr", 32'(wif.waddr), 0);
    checkOutput("ovfLevel", 32'(wif.wlevel), 16);
    checkOutput("ovfFull", 32'(wif.wfull), 1);
    applyStimulus(1'b0, 1'b0, '0);
    repeat (2) tick();
    checkOutput("ovfSticky", 32'(wif.woverflow), 1);
    applyStimulus(1'b1, 1'b1, '0);
    tick();
    checkOutput("ovfSetWins", 32'(wif.woverflow), 1);
    applyStimulus(1'b0, 1'b1, '0);
    tick();
    checkOutput("ovfClear", 32'(wif.woverflow), 0);

    // Read pointer jumps to Gray(4): visible in wfull/wlevel three edges later.
    $display("[TB] read-pointer latency");
    rp = 5'(grayOf(4));
    applyStimulus(1'b0, 1'b0, rp);
    tick();
    checkOutput("rdLatFull1", 32'(wif.wfull), 1);
    checkOutput("rdLatLevel1", 32'(wif.wlevel), 16);
    tick();
    checkOutput("rdLatFull2", 32'(wif.wfull), 1);
    checkOutput("rdLatLevel2", 32'(wif.wlevel), 16);
    tick();
    checkOutput("rdLatFull3", 32'(wif.wfull), 0);
    checkOutput("rdLatLevel3", 32'(wif.wlevel), 12);
    checkOutput("rdLatAlmost", 32'(wif.walmost_full), expAf(12));

    // Almost-full: rises on reaching level 14, falls back at level 13.
    $display("[TB] almost-full threshold");
    applyStimulus(1'b1, 1'b0, rp);
    tick();
    checkOutput("afLevel13", 32'(wif.wlevel), 13);
    checkOutput("afLow13", 32'(wif.walmost_full), expAf(13));
    checkOutput("afWaddr", 32'(wif.waddr), 1);
    tick();
    checkOutput("afLevel14", 32'(wif.wlevel), 14);
    checkOutput("afHigh14", 32'(wif.walmost_full), expAf(14));
    rp = 5'(grayOf(5));
    applyStimulus(1'b0, 1'b0, rp);
    repeat (2) tick();
    checkOutput("afHold", 32'(wif.walmost_full), expAf(14));
    tick();
    checkOutput("afFallLevel", 32'(wif.wlevel), 13);
    checkOutput("afFall", 32'(wif.walmost_full), expAf(13));
    checkOutput("afFull", 32'(wif.wfull), 0);

    // Reset both domains, then 40 writes with rptr trailing wptr by two cycles.
    $display("[TB] pointer wrap");
    applyStimulus(1'b0, 1'b0, '0);
    wrst_n = 1'b0;
    tick();
    checkOutput("re-rstWptr", 32'(wif.wptr), 0);
    checkOutput("re-rstLevel", 32'(wif.wlevel), 0);
    wrst_n = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      rp = (k >= 2) ? 5'(grayOf((k - 2) % 32)) : '0;
      applyStimulus(1'b1, 1'b0, rp);
      tick();
      checkOutput("wrapWptr", 32'(wif.wptr), grayOf((k + 1) % 32));
      checkOutput("wrapFull", 32'(wif.wfull), 0);
      checkOutput("wrapLevelMax", 32'(wif.wlevel <= 5'd16), 1);
    end
    checkOutput("wrapWaddr", 32'(wif.waddr), 8);
    checkOutput("wrapOvf", 32'(wif.woverflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
